// File: rtl/fifo_dot_drain_pkg.sv
// Shared types for the fifo_dot_drain slice: FSM state encoding and an
// accumulator-width helper usable in localparam expressions.
package fifo_dot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Smallest accumulator that can hold vec_len full-scale products without wrapping
    function automatic int min_acc_width(input int data_width, input int vec_len);
        return 2 * data_width + $clog2(vec_len);
    endfunction

endpackage

// File: rtl/fifo_dot_drain_if.sv
// Handshake bundle between the dot-product drain and its environment
// (two operand FIFOs plus the result consumer).
interface fifo_dot_drain_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) ();

    logic                  start;
    logic [DATA_WIDTH-1:0] a_data;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  a_empty;
    logic                  b_empty;
    logic                  rden;
    logic                  busy;
    logic [ACC_WIDTH-1:0]  result;
    logic                  result_valid;
    logic                  result_ready;

    modport master (
        output start, a_data, b_data, a_empty, b_empty, result_ready,
        input  rden, busy, result, result_valid
    );

    modport slave (
        input  start, a_data, b_data, a_empty, b_empty, result_ready,
        output rden, busy, result, result_valid
    );

endinterface

// File: rtl/fifo_dot_drain_mac.sv
// Registered multiply-accumulate with synchronous clear and enable.
// Define FIFO_DOT_SATURATE_EN to clamp at the maximum instead of wrapping.
module mac_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);

    logic [2*DATA_WIDTH-1:0] product;
    logic [ACC_WIDTH-1:0]    addend;
    logic [ACC_WIDTH-1:0]    acc_next;

    assign product = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    assign addend  = ACC_WIDTH'(product);

`ifdef FIFO_DOT_SATURATE_EN
    // Once clamped, any further addend overflows again, so the maximum sticks until clear
    logic [ACC_WIDTH:0] sum;
    assign sum      = {1'b0, acc} + {1'b0, addend};
    assign acc_next = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
    assign acc_next = acc + addend;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/fifo_dot_drain.sv
// Pops VEC_LEN pairs from two FIFOs, accumulates their products and offers
// the dot product on a valid/ready port. Optional FIFO_DOT_SATURATE_EN clamps the sum.
module fifo_dot_drain
    import fifo_dot_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_dot_drain_if.slave   bus
);

    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] VEC_LEN_C  = CNT_W'(VEC_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT_C = CNT_W'(VEC_LEN - 1);

    state_t               state;
    logic [CNT_W-1:0]     issue_cnt;
    logic                 rd_q;
    logic                 rden;
    logic                 busy_r;
    logic                 valid_r;
    logic                 acc_clear;
    logic [ACC_WIDTH-1:0] acc;

    // Read enable must react to an empty FIFO in the same cycle, so it stays combinational
    assign rden = (state == RUN) && !bus.a_empty && !bus.b_empty && (issue_cnt < VEC_LEN_C);

    assign acc_clear = (state == IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            issue_cnt <= '0;
            rd_q      <= 1'b0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
        end else begin
            rd_q <= rden;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        issue_cnt <= '0;
                        busy_r    <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (rden) begin
                        issue_cnt <= issue_cnt + CNT_W'(1);
                        if (issue_cnt == LAST_CNT_C) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    valid_r <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (bus.result_ready) begin
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (acc_clear),
        .en    (rd_q),
        .a     (bus.a_data),
        .b     (bus.b_data),
        .acc   (acc)
    );

    assign bus.rden         = rden;
    assign bus.busy         = busy_r;
    assign bus.result       = acc;
    assign bus.result_valid = valid_r;

endmodule

// File: tb/tb_fifo_dot_drain.sv
// Directed bench for fifo_dot_drain: a main 8x8 instance fed by a FIFO model,
// and a VEC_LEN=2/ACC_WIDTH=16 instance for the wrap/saturate boundary.
module tb_fifo_dot_drain;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    fifo_dot_drain_if #(.DATA_WIDTH(8), .ACC_WIDTH(24)) m_if ();
    fifo_dot_drain_if #(.DATA_WIDTH(8), .ACC_WIDTH(16)) s_if ();

    fifo_dot_drain #(.DATA_WIDTH(8), .VEC_LEN(8), .ACC_WIDTH(24)) dut_main (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if)
    );

    fifo_dot_drain #(.DATA_WIDTH(8), .VEC_LEN(2), .ACC_WIDTH(16)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand FIFO model: registered read data, zero when no read is accepted
    logic [7:0] mem_a [32];
    logic [7:0] mem_b [32];
    int         fifo_cnt;
    int         a_ptr;
    int         b_ptr;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       fifo_clear;
    logic       a_force_empty;
    logic [7:0] s_q;

    assign m_if.a_empty = a_force_empty || (a_ptr >= fifo_cnt);
    assign m_if.b_empty = (b_ptr >= fifo_cnt);
    assign m_if.a_data  = a_q;
    assign m_if.b_data  = b_q;

    always @(posedge clk) begin
        if (fifo_clear) begin
            a_ptr <= 0;
            b_ptr <= 0;
            a_q   <= 8'd0;
            b_q   <= 8'd0;
        end else if (m_if.rden && !m_if.a_empty && !m_if.b_empty) begin
            a_q   <= mem_a[a_ptr];
            b_q   <= mem_b[b_ptr];
            a_ptr <= a_ptr + 1;
            b_ptr <= b_ptr + 1;
        end else begin
            a_q <= 8'd0;
            b_q <= 8'd0;
        end
    end

    // Small instance sees FIFOs that never run dry and always hold 255
    assign s_if.a_empty = 1'b0;
    assign s_if.b_empty = 1'b0;
    assign s_if.a_data  = s_q;
    assign s_if.b_data  = s_q;

    always @(posedge clk) begin
        s_q <= s_if.rden ? 8'hFF : 8'h00;
    end

    task automatic load_fifo(input int mode);
        @(negedge clk);
        fifo_clear = 1'b1;
        @(negedge clk);
        fifo_clear = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (mode == 0) begin
                mem_a[i] = (i < 8) ? 8'(i + 1) : 8'd1;
            end else begin
                mem_a[i] = 8'(i + 1);
            end
            mem_b[i] = 8'd2;
        end
        fifo_cnt = 16;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (m_if.rden !== 1'b0 || m_if.busy !== 1'b0 || m_if.result_valid !== 1'b0 || m_if.result !== 24'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_main: rden=%b busy=%b valid=%b result=%0d expected all 0",
                     m_if.rden, m_if.busy, m_if.result_valid, m_if.result);
        end
        n_checks++;
        if (s_if.rden !== 1'b0 || s_if.busy !== 1'b0 || s_if.result_valid !== 1'b0 || s_if.result !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_small: rden=%b busy=%b valid=%b result=%0d expected all 0",
                     s_if.rden, s_if.busy, s_if.result_valid, s_if.result);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int rden_cnt;
        rden_cnt = 0;
        load_fifo(0);
        m_if.result_ready = 1'b1;
        @(negedge clk);
        m_if.start = 1'b1;
        @(negedge clk);
        m_if.start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            #1;
            if (m_if.rden === 1'b1) rden_cnt++;
            n_checks++;
            if (m_if.rden !== (c <= 8)) begin
                n_fail++;
                $display("[TB] FAIL basic_rden cycle %0d: got %b expected %b", c, m_if.rden, (c <= 8));
            end
            n_checks++;
            if (m_if.result_valid !== (c == 10)) begin
                n_fail++;
                $display("[TB] FAIL basic_valid cycle %0d: got %b expected %b", c, m_if.result_valid, (c == 10));
            end
            if (c == 10) begin
                n_checks++;
                if (m_if.result !== 24'd72) begin
                    n_fail++;
                    $display("[TB] FAIL basic_result: got %0d expected 72", m_if.result);
                end
            end
            if (c == 11) begin
                n_checks++;
                if (m_if.busy !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL basic_idle_busy: got %b expected 0", m_if.busy);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (rden_cnt != 8) begin
            n_fail++;
            $display("[TB] FAIL basic_read_count: got %0d expected 8", rden_cnt);
        end
    endtask

    task automatic test_stall();
        logic exp_rden;
        load_fifo(0);
        m_if.result_ready = 1'b1;
        @(negedge clk);
        m_if.start = 1'b1;
        @(negedge clk);
        m_if.start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            a_force_empty = (c == 3 || c == 4);
            #1;
            exp_rden = (c <= 2) || (c >= 5 && c <= 10);
            n_checks++;
            if (m_if.rden !== exp_rden) begin
                n_fail++;
                $display("[TB] FAIL stall_rden cycle %0d: got %b expected %b", c, m_if.rden, exp_rden);
            end
            n_checks++;
            if (m_if.result_valid !== (c == 12)) begin
                n_fail++;
                $display("[TB] FAIL stall_valid cycle %0d: got %b expected %b", c, m_if.result_valid, (c == 12));
            end
            if (c == 12) begin
                n_checks++;
                if (m_if.result !== 24'd72) begin
                    n_fail++;
                    $display("[TB] FAIL stall_result: got %0d expected 72", m_if.result);
                end
            end
            @(negedge clk);
        end
        a_force_empty = 1'b0;
    endtask

    task automatic test_hold();
        load_fifo(0);
        m_if.result_ready = 1'b0;
        @(negedge clk);
        m_if.start = 1'b1;
        @(negedge clk);
        m_if.start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            m_if.start        = (c == 12);
            m_if.result_ready = (c >= 15);
            #1;
            if (c >= 10 && c <= 15) begin
                n_checks++;
                if (m_if.result_valid !== 1'b1 || m_if.result !== 24'd72 || m_if.rden !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL hold_done cycle %0d: valid=%b result=%0d rden=%b expected 1/72/0",
                             c, m_if.result_valid, m_if.result, m_if.rden);
                end
            end
            if (c >= 16) begin
                n_checks++;
                if (m_if.busy !== 1'b0 || m_if.result_valid !== 1'b0 || m_if.rden !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL hold_release cycle %0d: busy=%b valid=%b rden=%b expected 0/0/0",
                             c, m_if.busy, m_if.result_valid, m_if.rden);
                end
            end
            @(negedge clk);
        end
        m_if.start = 1'b0;
    endtask

    task automatic test_wrap_saturate();
        logic [15:0] exp_result;
`ifdef FIFO_DOT_SATURATE_EN
        exp_result = 16'd65535;
`else
        exp_result = 16'd64514;
`endif
        s_if.result_ready = 1'b1;
        @(negedge clk);
        s_if.start = 1'b1;
        @(negedge clk);
        s_if.start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            n_checks++;
            if (s_if.rden !== (c <= 2)) begin
                n_fail++;
                $display("[TB] FAIL small_rden cycle %0d: got %b expected %b", c, s_if.rden, (c <= 2));
            end
            if (c == 4) begin
                n_checks++;
                if (s_if.result_valid !== 1'b1 || s_if.result !== exp_result) begin
                    n_fail++;
                    $display("[TB] FAIL small_result: valid=%b result=%0d expected 1/%0d",
                             s_if.result_valid, s_if.result, exp_result);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        load_fifo(1);
        m_if.result_ready = 1'b1;
        @(negedge clk);
        m_if.start = 1'b1;
        @(negedge clk);
        m_if.start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (m_if.result !== 24'd6 || m_if.busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midrst_before: result=%0d busy=%b expected 6/1", m_if.result, m_if.busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_if.rden !== 1'b0 || m_if.busy !== 1'b0 || m_if.result_valid !== 1'b0 || m_if.result !== 24'd0) begin
            n_fail++;
            $display("[TB] FAIL midrst_outputs: rden=%b busy=%b valid=%b result=%0d expected all 0",
                     m_if.rden, m_if.busy, m_if.result_valid, m_if.result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_if.start = 1'b1;
        @(negedge clk);
        m_if.start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            #1;
            if (c == 10) begin
                n_checks++;
                if (m_if.result_valid !== 1'b1 || m_if.result !== 24'd120) begin
                    n_fail++;
                    $display("[TB] FAIL midrst_result: valid=%b result=%0d expected 1/120",
                             m_if.result_valid, m_if.result);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        load_fifo(0);
        m_if.result_ready = 1'b1;
        @(negedge clk);
        m_if.start = 1'b1;
        @(negedge clk);
        m_if.start = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            m_if.start = (c == 11);
            #1;
            if (c == 10 || c == 21) begin
                n_checks++;
                if (m_if.result_valid !== 1'b1 || m_if.result !== ((c == 10) ? 24'd72 : 24'd16)) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_result cycle %0d: valid=%b result=%0d expected 1/%0d",
                             c, m_if.result_valid, m_if.result, (c == 10) ? 72 : 16);
                end
            end
            if (c == 11 || c == 22) begin
                n_checks++;
                if (m_if.busy !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_idle cycle %0d: busy=%b expected 0", c, m_if.busy);
                end
            end
            if (c == 12) begin
                n_checks++;
                if (m_if.busy !== 1'b1 || m_if.rden !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_restart: busy=%b rden=%b expected 1/1", m_if.busy, m_if.rden);
                end
            end
            @(negedge clk);
        end
        m_if.start = 1'b0;
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst_n             = 1'b0;
        fifo_clear        = 1'b1;
        fifo_cnt          = 0;
        a_force_empty     = 1'b0;
        m_if.start        = 1'b0;
        m_if.result_ready = 1'b0;
        s_if.start        = 1'b0;
        s_if.result_ready = 1'b0;

        test_reset();
        test_basic();
        test_stall();
        test_hold();
        test_wrap_saturate();
        test_mid_reset();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
